// File: rtl/uart_loader_pkg.sv
// Shared types and helpers for the UART instruction loader.
// Holds the receiver state encoding, parity modes and the parity function.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Expected parity bit for a zero-extended character.
  function automatic logic calc_parity(input logic [31:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_instr_loader_if.sv
// Host-side serial input and instruction-memory write bus of the loader.
// The loader uses the slave view; whoever feeds it uses the master view.
interface uart_instr_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              i_rx;
  logic              i_enable;
  logic              o_wr_en;
  logic [ADDR_W-1:0] o_wr_addr;
  logic [DATA_W-1:0] o_wr_data;
  logic [ADDR_W-1:0] o_max_addr;
  logic              o_transmit_done;
  logic              o_frame_err;
  logic              o_parity_err;
  logic              o_overflow;

  modport master (
    output i_rx, i_enable,
    input  o_wr_en, o_wr_addr, o_wr_data, o_max_addr,
    input  o_transmit_done, o_frame_err, o_parity_err, o_overflow
  );

  modport slave (
    input  i_rx, i_enable,
    output o_wr_en, o_wr_addr, o_wr_data, o_max_addr,
    output o_transmit_done, o_frame_err, o_parity_err, o_overflow
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART character receiver: synchroniser, bit-timing FSM and parity/stop checks.
// Emits single-cycle pulses on the stop-bit sample cycle.
module uart_rx_core
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 enable,
  input  logic                 hold,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 start_det,
  output logic                 abort,
  output logic                 idle
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  rx_state_t            state, state_next;
  logic                 rx_meta, rx_sync, rx_prev;
  logic [CW-1:0]        clk_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 parity_bad;
  logic                 cnt_clear, data_sample, half_tick, full_tick;

  assign half_tick = (clk_cnt == HALF_LAST);
  assign full_tick = (clk_cnt == FULL_LAST);
  assign byte_data = shift_reg;
  assign idle      = (state == ST_IDLE);

  always_comb begin
    state_next  = state;
    cnt_clear   = 1'b0;
    data_sample = 1'b0;
    byte_valid  = 1'b0;
    frame_err   = 1'b0;
    parity_err  = 1'b0;
    start_det   = 1'b0;
    abort       = 1'b0;
    // Dropping enable mid-character abandons it from any active state
    if (state != ST_IDLE && !enable) begin
      abort      = 1'b1;
      cnt_clear  = 1'b1;
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && !hold && rx_prev && !rx_sync) begin
            start_det  = 1'b1;
            cnt_clear  = 1'b1;
            state_next = ST_START;
          end
        end
        ST_START: begin
          if (half_tick) begin
            cnt_clear  = 1'b1;
            state_next = rx_sync ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (full_tick) begin
            cnt_clear   = 1'b1;
            data_sample = 1'b1;
            if (bit_cnt == BIT_LAST)
              state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (full_tick) begin
            cnt_clear  = 1'b1;
            parity_err = (rx_sync != calc_parity(32'(shift_reg), PARITY));
            state_next = ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_tick) begin
            cnt_clear = 1'b1;
            if (rx_sync) begin
              byte_valid = !parity_bad;
              state_next = ST_IDLE;
            end else begin
              frame_err  = 1'b1;
              state_next = ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_sync) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= ST_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bad <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      state   <= state_next;
      clk_cnt <= (cnt_clear || state == ST_IDLE) ? '0 : clk_cnt + 1'b1;
      if (start_det) begin
        bit_cnt    <= '0;
        parity_bad <= 1'b0;
      end
      if (data_sample) begin
        shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
      if (parity_err) parity_bad <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_instr_loader.sv
// Packs received characters into instruction words and writes them to memory,
// ending the session after an idle timeout and keeping sticky error flags.
module uart_instr_loader
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT      = 868,
  parameter int DATA_BITS         = 8,
  parameter int PARITY            = 0,
  parameter int WORD_BYTES        = 2,
  parameter int ADDR_W            = 8,
  parameter int START_ADDR        = 1,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input logic                i_clk,
  input logic                i_rst_n,
  uart_instr_loader_if.slave bus
);

  localparam int WORD_W         = WORD_BYTES * DATA_BITS;
  localparam int TIMEOUT_CYCLES = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW             = $clog2(WORD_BYTES + 1);
  localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [NW-1:0]     LAST_BYTE    = NW'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR    = {ADDR_W{1'b1}};

  logic [DATA_BITS-1:0] byte_data;
  logic                 byte_valid, frame_pulse, parity_pulse, start_det, abort, rx_idle;
  logic [WORD_W-1:0]    word_reg, word_next;
  logic [NW-1:0]        byte_cnt;
  logic [ADDR_W-1:0]    ptr, wr_addr, max_addr;
  logic [WORD_W-1:0]    wr_data;
  logic [TW-1:0]        idle_cnt;
  logic                 ptr_full, char_seen, wr_en, done, frame_err, parity_err, overflow;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .DATA_BITS   (DATA_BITS),
    .PARITY      (PARITY)
  ) u_rx (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .rx        (bus.i_rx),
    .enable    (bus.i_enable),
    .hold      (done),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_pulse),
    .parity_err(parity_pulse),
    .start_det (start_det),
    .abort     (abort),
    .idle      (rx_idle)
  );

  // First character received ends up in the most significant position
  assign word_next = (word_reg << DATA_BITS) | WORD_W'(byte_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      word_reg   <= '0;
      byte_cnt   <= '0;
      ptr        <= ADDR_W'(START_ADDR);
      ptr_full   <= 1'b0;
      char_seen  <= 1'b0;
      idle_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      max_addr   <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (frame_pulse)  frame_err  <= 1'b1;
      if (parity_pulse) parity_err <= 1'b1;

      if (abort) begin
        byte_cnt  <= '0;
        word_reg  <= '0;
        char_seen <= 1'b0;
      end else if (byte_valid && !done) begin
        char_seen <= 1'b1;
        if (byte_cnt == LAST_BYTE) begin
          byte_cnt <= '0;
          word_reg <= '0;
          if (ptr_full) begin
            overflow <= 1'b1;
          end else begin
            wr_en    <= 1'b1;
            wr_addr  <= ptr;
            wr_data  <= word_next;
            max_addr <= ptr;
            // Pointer parks on the last address; the full flag blocks later words
            if (ptr == LAST_ADDR) ptr_full <= 1'b1;
            else                  ptr      <= ptr + 1'b1;
          end
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          word_reg <= word_next;
        end
      end

      if (start_det) begin
        idle_cnt <= '0;
      end else if (rx_idle && char_seen && !done) begin
        if (idle_cnt == TIMEOUT_LAST) begin
          done <= 1'b1;
          if (byte_cnt != '0) begin
            frame_err <= 1'b1;
            byte_cnt  <= '0;
            word_reg  <= '0;
          end
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.o_wr_en         = wr_en;
  assign bus.o_wr_addr       = wr_addr;
  assign bus.o_wr_data       = wr_data;
  assign bus.o_max_addr      = max_addr;
  assign bus.o_transmit_done = done;
  assign bus.o_frame_err     = frame_err;
  assign bus.o_parity_err    = parity_err;
  assign bus.o_overflow      = overflow;

endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: four instances cover default timing,
// even parity, a 2-bit address space and error/reset/timeout handling.
module tb_uart_instr_loader;

  logic clk;
  logic txLine;
  int   txSel;
  logic rstA, rstB, rstC, rstD;
  logic enA, enB, enC, enD;
  int   totalChecks;
  int   badChecks;

  int          wrCntA, wrCntB, wrCntC, wrCntD;
  logic [7:0]  wrAddrA[8], wrAddrB[8], wrAddrC[8], wrAddrD[8];
  logic [15:0] wrDataA[8], wrDataB[8], wrDataC[8], wrDataD[8];

  uart_instr_loader_if #(.ADDR_W(8), .DATA_W(16)) busA ();
  uart_instr_loader_if #(.ADDR_W(8), .DATA_W(16)) busB ();
  uart_instr_loader_if #(.ADDR_W(2), .DATA_W(16)) busC ();
  uart_instr_loader_if #(.ADDR_W(8), .DATA_W(16)) busD ();

  assign busA.i_rx = (txSel == 0) ? txLine : 1'b1;
  assign busB.i_rx = (txSel == 1) ? txLine : 1'b1;
  assign busC.i_rx = (txSel == 2) ? txLine : 1'b1;
  assign busD.i_rx = (txSel == 3) ? txLine : 1'b1;
  assign busA.i_enable = enA;
  assign busB.i_enable = enB;
  assign busC.i_enable = enC;
  assign busD.i_enable = enD;

  uart_instr_loader #(.CLKS_PER_BIT(868)) dutA (
    .i_clk(clk), .i_rst_n(rstA), .bus(busA.slave));
  uart_instr_loader #(.CLKS_PER_BIT(16), .PARITY(1)) dutB (
    .i_clk(clk), .i_rst_n(rstB), .bus(busB.slave));
  uart_instr_loader #(.CLKS_PER_BIT(16), .ADDR_W(2), .START_ADDR(1)) dutC (
    .i_clk(clk), .i_rst_n(rstC), .bus(busC.slave));
  uart_instr_loader #(.CLKS_PER_BIT(16)) dutD (
    .i_clk(clk), .i_rst_n(rstD), .bus(busD.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-strobe monitors, one per instance, sampled on the falling edge
  always @(negedge clk) begin
    if (busA.o_wr_en === 1'b1) begin
      if (wrCntA < 8) begin wrAddrA[wrCntA] = busA.o_wr_addr; wrDataA[wrCntA] = busA.o_wr_data; end
      wrCntA++;
    end
    if (busB.o_wr_en === 1'b1) begin
      if (wrCntB < 8) begin wrAddrB[wrCntB] = busB.o_wr_addr; wrDataB[wrCntB] = busB.o_wr_data; end
      wrCntB++;
    end
    if (busC.o_wr_en === 1'b1) begin
      if (wrCntC < 8) begin wrAddrC[wrCntC] = 8'(busC.o_wr_addr); wrDataC[wrCntC] = busC.o_wr_data; end
      wrCntC++;
    end
    if (busD.o_wr_en === 1'b1) begin
      if (wrCntD < 8) begin wrAddrD[wrCntD] = busD.o_wr_addr; wrDataD[wrCntD] = busD.o_wr_data; end
      wrCntD++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    totalChecks++;
    if (actual !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  // Sends one 8-bit character; parityBit < 0 means no parity bit
  task automatic applyStimulus(input int sel, input int clks, input logic [7:0] data,
                               input int parityBit, input logic stopBit);
    txSel = sel;
    @(negedge clk);
    txLine = 1'b0;
    repeat (clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      txLine = data[i];
      repeat (clks) @(negedge clk);
    end
    if (parityBit >= 0) begin
      txLine = (parityBit != 0);
      repeat (clks) @(negedge clk);
    end
    txLine = stopBit;
    repeat (clks) @(negedge clk);
    txLine = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic settle(input int cycles);
    repeat (cycles) @(negedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    totalChecks = 0;
    badChecks = 0;
    wrCntA = 0; wrCntB = 0; wrCntC = 0; wrCntD = 0;
    txLine = 1'b1;
    txSel = 0;
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0; rstD = 1'b0;
    enA = 1'b1; enB = 1'b1; enC = 1'b1; enD = 1'b1;
    settle(5);
    checkOutput("rst_wr_en", 32'(busA.o_wr_en), 0);
    checkOutput("rst_max_addr", 32'(busA.o_max_addr), 0);
    checkOutput("rst_done", 32'(busA.o_transmit_done), 0);
    checkOutput("rst_flags", {29'd0, busA.o_frame_err, busA.o_parity_err, busA.o_overflow}, 0);
    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1; rstD = 1'b1;
    settle(10);

    $display("[TB] glitch rejection on default instance");
    txSel = 0;
    txLine = 1'b0;
    settle(300);
    txLine = 1'b1;
    settle(600);
    checkOutput("glitch_writes", wrCntA, 0);
    checkOutput("glitch_flags", {30'd0, busA.o_frame_err, busA.o_parity_err}, 0);
    checkOutput("glitch_done", 32'(busA.o_transmit_done), 0);

    $display("[TB] default 8N1 words");
    applyStimulus(0, 868, 8'h41, -1, 1'b1);
    applyStimulus(0, 868, 8'h00, -1, 1'b1);
    applyStimulus(0, 868, 8'h81, -1, 1'b1);
    applyStimulus(0, 868, 8'h80, -1, 1'b1);
    settle(1);
    checkOutput("a_wr_count", wrCntA, 2);
    checkOutput("a_wr0_addr", wrAddrA[0], 1);
    checkOutput("a_wr0_data", wrDataA[0], 32'h4100);
    checkOutput("a_wr1_addr", wrAddrA[1], 2);
    checkOutput("a_wr1_data", wrDataA[1], 32'h8180);
    checkOutput("a_max_addr", 32'(busA.o_max_addr), 2);
    settle(16000);
    checkOutput("a_done_early", 32'(busA.o_transmit_done), 0);
    settle(1500);
    checkOutput("a_done_timeout", 32'(busA.o_transmit_done), 1);
    checkOutput("a_no_frame_err", 32'(busA.o_frame_err), 0);

    $display("[TB] even parity");
    applyStimulus(1, 16, 8'h41, 1, 1'b1);
    settle(1);
    checkOutput("b_parity_err", 32'(busB.o_parity_err), 1);
    checkOutput("b_bad_no_write", wrCntB, 0);
    applyStimulus(1, 16, 8'h41, 0, 1'b1);
    applyStimulus(1, 16, 8'h00, 0, 1'b1);
    applyStimulus(1, 16, 8'h07, 1, 1'b1);
    applyStimulus(1, 16, 8'h80, 1, 1'b1);
    settle(1);
    checkOutput("b_wr_count", wrCntB, 2);
    checkOutput("b_wr0_addr", wrAddrB[0], 1);
    checkOutput("b_wr0_data", wrDataB[0], 32'h4100);
    checkOutput("b_wr1_data", wrDataB[1], 32'h0780);
    checkOutput("b_frame_err", 32'(busB.o_frame_err), 0);

    $display("[TB] enable drop mid-character");
    applyStimulus(1, 16, 8'h55, 0, 1'b1);
    txSel = 1;
    txLine = 1'b0;
    settle(40);
    enB = 1'b0;
    settle(2);
    txLine = 1'b1;
    settle(10);
    enB = 1'b1;
    settle(10);
    applyStimulus(1, 16, 8'h01, 1, 1'b1);
    applyStimulus(1, 16, 8'h02, 1, 1'b1);
    settle(1);
    checkOutput("b_abort_count", wrCntB, 3);
    checkOutput("b_abort_addr", wrAddrB[2], 3);
    checkOutput("b_abort_data", wrDataB[2], 32'h0102);

    $display("[TB] address overflow with 2-bit pointer");
    applyStimulus(2, 16, 8'h11, -1, 1'b1);
    applyStimulus(2, 16, 8'h22, -1, 1'b1);
    applyStimulus(2, 16, 8'h33, -1, 1'b1);
    applyStimulus(2, 16, 8'h44, -1, 1'b1);
    applyStimulus(2, 16, 8'h55, -1, 1'b1);
    applyStimulus(2, 16, 8'h66, -1, 1'b1);
    settle(1);
    checkOutput("c_no_overflow_yet", 32'(busC.o_overflow), 0);
    applyStimulus(2, 16, 8'h77, -1, 1'b1);
    applyStimulus(2, 16, 8'h88, -1, 1'b1);
    settle(1);
    checkOutput("c_wr_count", wrCntC, 3);
    checkOutput("c_wr2_addr", wrAddrC[2], 3);
    checkOutput("c_wr2_data", wrDataC[2], 32'h5566);
    checkOutput("c_overflow", 32'(busC.o_overflow), 1);
    checkOutput("c_max_addr", 32'(busC.o_max_addr), 3);

    $display("[TB] bad stop bit");
    applyStimulus(3, 16, 8'hE0, -1, 1'b0);
    settle(1);
    checkOutput("d_frame_err", 32'(busD.o_frame_err), 1);
    checkOutput("d_bad_no_write", wrCntD, 0);
    applyStimulus(3, 16, 8'hE0, -1, 1'b1);
    applyStimulus(3, 16, 8'h00, -1, 1'b1);
    settle(1);
    checkOutput("d_wr_count", wrCntD, 1);
    checkOutput("d_wr0_addr", wrAddrD[0], 1);
    checkOutput("d_wr0_data", wrDataD[0], 32'hE000);

    $display("[TB] partial word at timeout");
    rstD = 1'b0;
    settle(3);
    checkOutput("d_rst_flags", {30'd0, busD.o_frame_err, busD.o_transmit_done}, 0);
    checkOutput("d_rst_max_addr", 32'(busD.o_max_addr), 0);
    rstD = 1'b1;
    settle(3);
    applyStimulus(3, 16, 8'h12, -1, 1'b1);
    applyStimulus(3, 16, 8'h34, -1, 1'b1);
    applyStimulus(3, 16, 8'h56, -1, 1'b1);
    settle(1);
    checkOutput("d_part_count", wrCntD, 2);
    checkOutput("d_part_data", wrDataD[1], 32'h1234);
    checkOutput("d_part_frame_before", 32'(busD.o_frame_err), 0);
    checkOutput("d_part_done_before", 32'(busD.o_transmit_done), 0);
    settle(400);
    checkOutput("d_part_done", 32'(busD.o_transmit_done), 1);
    checkOutput("d_part_frame_err", 32'(busD.o_frame_err), 1);
    applyStimulus(3, 16, 8'h9A, -1, 1'b1);
    applyStimulus(3, 16, 8'hBC, -1, 1'b1);
    settle(1);
    checkOutput("d_ignored_after_done", wrCntD, 2);

    $display("[TB] reset mid-word and mid-character");
    rstD = 1'b0;
    settle(2);
    rstD = 1'b1;
    settle(3);
    applyStimulus(3, 16, 8'hAA, -1, 1'b1);
    txSel = 3;
    txLine = 1'b0;
    settle(40);
    rstD = 1'b0;
    settle(1);
    checkOutput("d_midrst_outs", {26'd0, busD.o_wr_en, busD.o_transmit_done, busD.o_frame_err,
                                  busD.o_parity_err, busD.o_overflow, 1'b0}, 0);
    checkOutput("d_midrst_max", 32'(busD.o_max_addr), 0);
    txLine = 1'b1;
    settle(3);
    rstD = 1'b1;
    settle(3);
    applyStimulus(3, 16, 8'hCA, -1, 1'b1);
    applyStimulus(3, 16, 8'hFE, -1, 1'b1);
    settle(1);
    checkOutput("d_post_rst_count", wrCntD, 3);
    checkOutput("d_post_rst_addr", wrAddrD[2], 1);
    checkOutput("d_post_rst_data", wrDataD[2], 32'hCAFE);
    checkOutput("d_post_rst_frame", 32'(busD.o_frame_err), 0);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
